// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n shared definitions.
// Mode encodings for the direct/scan select input.
package mux_scan_n_pkg;

    localparam logic MUX_MODE_DIRECT = 1'b0;
    localparam logic MUX_MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_n_muxb.sv
// muxb_n: combinational N:1 binary-select mux over a packed K-bit bus.
// Channel i lives at d[i*K +: K].
module muxb_n #(
    parameter int K = 4,
    parameter int N = 8,
    localparam int S = $clog2(N)
) (
    input  logic [N*K-1:0] d,
    input  logic [S-1:0]   sel,
    output logic [K-1:0]   y
);

    assign y = d[sel*K +: K];

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel registered mux, direct select or round-robin scan.
// Define MUX_SCAN_PARITY_EN to add the registered even-parity output out_par.
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int K     = 4,
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [LOG2N-1:0] sel,
    input  logic [N-1:0]     mask,
    input  logic [N*K-1:0]   d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [K-1:0]     out,
    output logic [LOG2N-1:0] out_ch
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic [LOG2N-1:0] ptr;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [LOG2N-1:0] off;
    logic [LOG2N-1:0] c;
    logic [LOG2N-1:0] idx;
    logic             any;
    logic             hit;
    logic             scan;
    logic             load;
    logic [K-1:0]     dsel;

    // rot[j] is the enable of channel (ptr + j) mod N
    assign dbl = {mask, mask} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        off = '0;
        any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = LOG2N'(j);
                any = 1'b1;
            end
        end
    end

    assign c    = ptr + off;
    assign scan = (mode == MUX_MODE_SCAN);
    assign idx  = scan ? c : sel;
    assign hit  = scan ? any : mask[sel];
    assign load = !out_valid || out_ready;

    muxb_n #(
        .K (K),
        .N (N)
    ) u_mux (
        .d   (d),
        .sel (idx),
        .y   (dsel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (hit) begin
                out       <= dsel;
                out_ch    <= idx;
                out_valid <= 1'b1;
                if (scan)
                    ptr <= c + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            out_par <= 1'b0;
        else if (load && hit)
            out_par <= ^dsel;
    end
`else
`endif

endmodule
